// File: rtl/pipe_control_unit.sv
// Pipelined control for the five-stage WISC-F24 core: decodes the ID opcode, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, and inserts load-use / squash / halt bubbles.
module pipe_control_unit #(
  parameter int REG_W          = 4,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter bit HALT_AT_WB     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush_ifid,
  input  logic             stall_ext,
  output logic             id_branch,
  output logic             id_branchr,
  output logic             id_pcs,
  output logic             stall_if_id,
  output logic             fetch_stop,
  output logic             ex_valid,
  output logic             ex_alu_src,
  output logic             ex_llb_en,
  output logic             ex_hlb_en,
  output logic             ex_reg_dst,
  output logic [2:0]       ex_flag_en,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             wb_pcs,
  output logic [REG_W-1:0] wb_rd,
  output logic             halted
);

  typedef struct packed {
    logic             alu_src, llb_en, hlb_en, reg_dst;
    logic [2:0]       flag_en;
    logic             mem_read, mem_write, reg_write, mem_to_reg, pcs, halt;
    logic [REG_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic             mem_read, mem_write, reg_write, mem_to_reg, pcs, halt;
    logic [REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic             reg_write, mem_to_reg, pcs;
    logic [REG_W-1:0] rd;
  } wb_t;

  logic [3:0]       opc;
  logic [REG_W-1:0] f_rd, f_rs, f_rt;
  ex_t              dec;
  logic             dec_branch, dec_branchr;
  logic             use_rs, use_rt, use_rd;
  logic             rd_hit, load_use, kill;

  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [2:0]       vld_pipe_q, vld_pipe_d;   // [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
  logic             fetch_stop_q, fetch_stop_d;
  logic             halted_q, halted_d;

  assign opc  = id_instr[15:12];
  assign f_rd = id_instr[8 +: REG_W];
  assign f_rs = id_instr[4 +: REG_W];
  assign f_rt = id_instr[0 +: REG_W];

  always_comb begin
    dec         = '0;
    dec_branch  = 1'b0;
    dec_branchr = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    use_rd      = 1'b0;
    case (opc)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0110: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; use_rs = 1'b1;
      end
      4'b1000: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
        dec.mem_to_reg = 1'b1; use_rs = 1'b1;
      end
      4'b1001: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; use_rs = 1'b1; use_rd = 1'b1;
      end
      4'b1010: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.llb_en = 1'b1; use_rd = 1'b1;
      end
      4'b1011: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.hlb_en = 1'b1; use_rd = 1'b1;
      end
      4'b1100: dec_branch = 1'b1;
      4'b1101: begin dec_branch = 1'b1; dec_branchr = 1'b1; use_rs = 1'b1; end
      4'b1110: begin dec.reg_write = 1'b1; dec.pcs = 1'b1; end
      default: dec.halt = 1'b1;
    endcase
    case (opc)
      4'b0000, 4'b0001:                   dec.flag_en = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: dec.flag_en = 3'b001;
      default:                            dec.flag_en = 3'b000;
    endcase
    if (dec.reg_write) dec.rd = f_rd;
  end

  // A load in EX whose destination feeds any register this ID instruction reads.
  assign rd_hit   = (use_rs && (ex_q.rd == f_rs)) || (use_rt && (ex_q.rd == f_rt)) ||
                    (use_rd && (ex_q.rd == f_rd));
  assign load_use = LOAD_USE_STALL && vld_pipe_q[0] && ex_q.mem_read && rd_hit && !flush_ifid;
  assign kill     = !id_valid || flush_ifid || fetch_stop_q || load_use;

  assign id_branch   = dec_branch  && !kill;
  assign id_branchr  = dec_branchr && !kill;
  assign id_pcs      = dec.pcs     && !kill;
  assign stall_if_id = load_use && !stall_ext;

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    vld_pipe_d   = vld_pipe_q;
    fetch_stop_d = fetch_stop_q;
    halted_d     = halted_q;
    if (!stall_ext) begin
      ex_d       = kill ? '0 : dec;
      mem_d      = '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                     reg_write: ex_q.reg_write, mem_to_reg: ex_q.mem_to_reg,
                     pcs: ex_q.pcs, halt: ex_q.halt, rd: ex_q.rd};
      wb_d       = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg,
                     pcs: mem_q.pcs, rd: mem_q.rd};
      vld_pipe_d = {vld_pipe_q[1:0], !kill};
      if (dec.halt && !kill) fetch_stop_d = 1'b1;
      if (HALT_AT_WB ? (vld_pipe_q[1] && mem_q.halt) : (dec.halt && !kill)) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      vld_pipe_q   <= '0;
      fetch_stop_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      vld_pipe_q   <= vld_pipe_d;
      fetch_stop_q <= fetch_stop_d;
      halted_q     <= halted_d;
    end
  end

  assign fetch_stop    = fetch_stop_q;
  assign halted        = halted_q;
  assign ex_valid      = vld_pipe_q[0];
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_llb_en     = ex_q.llb_en;
  assign ex_hlb_en     = ex_q.hlb_en;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_flag_en    = ex_q.flag_en;
  assign ex_rd         = ex_q.rd;
  assign mem_valid     = vld_pipe_q[1];
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign wb_valid      = vld_pipe_q[2];
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_pcs        = wb_q.pcs;
  assign wb_rd         = wb_q.rd;

endmodule
